// File: rtl/mbist_pat_pkg.sv
// mbist_pat_pkg
// Shared constants and types for the MBIST data-background generator.
//   - BIST_DATA_PAT_TYPE1..8 : table-mode data backgrounds (64-bit, replicated
//                              across wider data buses)
//   - pat_mode_e             : background selection mode
//   - pat_state_e            : sequencer state
//   - LFSR_TAPS              : Galois mask for x^32+x^22+x^2+x+1 (right shift)
//   - CHKR_PAT               : checkerboard base word
//   - pat_table / pat_bit    : table lookup helpers
//   - idx_width              : step-index width derivation
package mbist_pat_pkg;

    localparam logic [63:0] BIST_DATA_PAT_TYPE1 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] BIST_DATA_PAT_TYPE2 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BIST_DATA_PAT_TYPE3 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] BIST_DATA_PAT_TYPE4 = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] BIST_DATA_PAT_TYPE5 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] BIST_DATA_PAT_TYPE6 = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] BIST_DATA_PAT_TYPE7 = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] BIST_DATA_PAT_TYPE8 = 64'hF0F0_F0F0_F0F0_F0F0;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [63:0] CHKR_PAT  = 64'h5555_5555_5555_5555;

    typedef enum logic [1:0] {
        PAT_TABLE = 2'd0,
        PAT_WALK  = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_CHKR  = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } pat_state_e;

    // Step index 0 selects TYPE1, step 7 selects TYPE8.
    function automatic logic [63:0] pat_table(input logic [2:0] step);
        logic [63:0] entry;
        case (step)
            3'd0:    entry = BIST_DATA_PAT_TYPE1;
            3'd1:    entry = BIST_DATA_PAT_TYPE2;
            3'd2:    entry = BIST_DATA_PAT_TYPE3;
            3'd3:    entry = BIST_DATA_PAT_TYPE4;
            3'd4:    entry = BIST_DATA_PAT_TYPE5;
            3'd5:    entry = BIST_DATA_PAT_TYPE6;
            3'd6:    entry = BIST_DATA_PAT_TYPE7;
            default: entry = BIST_DATA_PAT_TYPE8;
        endcase
        return entry;
    endfunction

    function automatic logic pat_bit(input logic [2:0] step, input logic [5:0] bit_sel);
        logic [63:0] entry;
        entry = pat_table(step);
        return entry[bit_sel];
    endfunction

    // Never narrower than one bit so the scan chain always exists.
    function automatic int idx_width(input int cnt, input int wd);
        int m;
        m = (cnt > wd) ? cnt : wd;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mbist_pat_lfsr.sv
// mbist_pat_lfsr
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1, shift right, feedback from bit 0).
// Kept standalone so the MBIST address generator can share it.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, loads seed
//   seed  : load value (must be nonzero or the register locks at zero)
//   load  : load seed (wins over step)
//   step  : advance one state
//   lfsr  : current register value
module mbist_pat_lfsr
    import mbist_pat_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        step,
    output logic [31:0] lfsr
);

    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/mbist_pat_gen.sv
// mbist_pat_gen
// MBIST data-background generator. Steps through a sequence of patterns in
// table, walking-one, LFSR or address-checkerboard mode under start/adv
// control from the MBIST FSM; the step index is visible on the scan chain.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : latch cfg_mode, restart at step 0
//   adv           : advance to next pattern
//   cfg_mode      : 0 table, 1 walking-one, 2 LFSR, 3 checkerboard
//   pat_inv       : invert pat_data (March element polarity)
//   addr_par      : address parity, checkerboard mode only
//   scan_shift    : shift step index (sdi in at MSB, sdo out from LSB)
//   sdi, sdo      : scan in / out
//   pat_data      : current pattern (zero when not ACTIVE)
//   pat_valid     : state is ACTIVE
//   pat_last      : current step is the last of the sequence
//   busy          : state is not IDLE
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | after reset, no sequence running, adv ignored
// ACTIVE | pattern sequence running, pat_data valid
// DONE   | adv taken on the last step, waits for start
module mbist_pat_gen
    import mbist_pat_pkg::*;
#(
    parameter int          BIST_DATA_WD = 32,
    parameter int          PAT_CNT      = 8,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    adv,
    input  logic [1:0]              cfg_mode,
    input  logic                    pat_inv,
    input  logic                    addr_par,
    input  logic                    scan_shift,
    input  logic                    sdi,
    output logic                    sdo,
    output logic [BIST_DATA_WD-1:0] pat_data,
    output logic                    pat_valid,
    output logic                    pat_last,
    output logic                    busy
);

    localparam int IDX_WD = idx_width(PAT_CNT, BIST_DATA_WD);
    localparam logic [IDX_WD-1:0] LAST_WALK = IDX_WD'(BIST_DATA_WD - 1);
    localparam logic [IDX_WD-1:0] LAST_SEQ  = IDX_WD'(PAT_CNT - 1);

    pat_state_e              state_q, state_d;
    pat_mode_e               mode_q,  mode_d;
    logic [IDX_WD-1:0]       idx_q,   idx_d;
    logic [IDX_WD-1:0]       last_idx;
    logic                    lfsr_load;
    logic                    lfsr_step;
    logic [31:0]             lfsr_q;
    logic [2:0]              tab_sel;
    logic [BIST_DATA_WD-1:0] base;
    logic                    active;

    mbist_pat_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .load (lfsr_load),
        .step (lfsr_step),
        .lfsr (lfsr_q)
    );

    assign last_idx = (mode_q == PAT_WALK) ? LAST_WALK : LAST_SEQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= PAT_TABLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    // scan_shift beats start beats adv. A scanned-in index past the last
    // step is not clamped; the >= compare sends the next adv to DONE.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (scan_shift) begin
            idx_d = (idx_q >> 1) | (IDX_WD'(sdi) << (IDX_WD - 1));
        end else if (start) begin
            state_d   = ACTIVE;
            mode_d    = pat_mode_e'(cfg_mode);
            idx_d     = '0;
            lfsr_load = 1'b1;
        end else if (adv && (state_q == ACTIVE)) begin
            if (idx_q >= last_idx) begin
                state_d = DONE;
            end else begin
                idx_d     = idx_q + IDX_WD'(1);
                lfsr_step = (mode_q == PAT_LFSR);
            end
        end
    end

    // Table lookup wraps on the low three index bits, so a scanned-in index
    // beyond the table still yields a defined entry.
    assign tab_sel = 3'(idx_q);

    always_comb begin
        base = '0;
        unique case (mode_q)
            PAT_TABLE: begin
                for (int i = 0; i < BIST_DATA_WD; i++) begin
                    base[i] = pat_bit(tab_sel, 6'(i % 64));
                end
            end
            PAT_WALK: begin
                for (int i = 0; i < BIST_DATA_WD; i++) begin
                    base[i] = (idx_q == IDX_WD'(i));
                end
            end
            PAT_LFSR: begin
                for (int i = 0; i < BIST_DATA_WD; i++) begin
                    base[i] = lfsr_q[i % 32];
                end
            end
            PAT_CHKR: begin
                // Odd steps flip the background, odd addresses flip it again.
                for (int i = 0; i < BIST_DATA_WD; i++) begin
                    base[i] = CHKR_PAT[i % 64] ^ idx_q[0] ^ addr_par;
                end
            end
        endcase
    end

    assign active    = (state_q == ACTIVE);
    assign pat_valid = active;
    assign busy      = (state_q != IDLE);
    assign pat_last  = active && (idx_q == last_idx);
    assign pat_data  = active ? (base ^ {BIST_DATA_WD{pat_inv}}) : '0;
    assign sdo       = idx_q[0];

endmodule
